// File: rtl/hs32_memory_if.sv
// hs32 memory-stage shared types and data-bus interface.
//
// hs32_pkg
//   hs32_s3pkt : execute-stage result packet (rd, std, res, memwe, regwe)
//   hs32_stall : hazard/occupancy packet (rd, vld, lsu)
//
// hs32_memory_if : single-master request/acknowledge data bus
//   mem_addr_o  master -> slave, 32  bus address
//   mem_dat_o   master -> slave, 32  store data
//   mem_we_o    master -> slave, 1   1 = write
//   mem_stb_o   master -> slave, 1   request strobe
//   mem_dat_i   slave -> master, 32  read data
//   mem_ack_i   slave -> master, 1   transfer complete

package hs32_pkg;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] std;
    logic [31:0] res;
    logic        memwe;
    logic        regwe;
  } hs32_s3pkt;

  typedef struct packed {
    logic [3:0] rd;
    logic       vld;
    logic       lsu;
  } hs32_stall;

endpackage

interface hs32_memory_if;

  logic [31:0] mem_addr_o;
  logic [31:0] mem_dat_o;
  logic        mem_we_o;
  logic        mem_stb_o;
  logic [31:0] mem_dat_i;
  logic        mem_ack_i;

  modport master (
    output mem_addr_o,
    output mem_dat_o,
    output mem_we_o,
    output mem_stb_o,
    input  mem_dat_i,
    input  mem_ack_i
  );

  modport slave (
    input  mem_addr_o,
    input  mem_dat_o,
    input  mem_we_o,
    input  mem_stb_o,
    output mem_dat_i,
    output mem_ack_i
  );

endinterface

// File: rtl/hs32_memory.sv
// hs32_memory: memory-access stage of the hs32 pipeline.
//
// Accepts a load/store from execute while IDLE, runs one request/ack
// transaction on the data bus, and writes load results back to the
// register file one cycle after the ack. Occupancy is reported to
// execute through l1_o (request phase) and l2_o (writeback phase).
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   valid_i             execute holds a valid instruction
//   data_i              execute result packet (address in res)
//   s3_i                execute hazard packet, lsu marks load/store
//   bus (master)        data bus: addr/dat/we/stb out, dat/ack in
//   wp_addr_o/data_o/we_o  register-file write port
//   fwd_o               last loaded value, forwarded into execute
//   l1_o, l2_o          request / writeback occupancy packets
//   err_o               one-cycle pulse on bus timeout
//
// Parameters
//   TIMEOUT  bus-wait limit in cycles, 0 disables (must be < 2**CW)
//   CW       width of the wait counter

module hs32_memory
  import hs32_pkg::*;
#(
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned CW      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_i,
  input  hs32_s3pkt            data_i,
  input  hs32_stall            s3_i,
  hs32_memory_if.master        bus,
  output logic [3:0]           wp_addr_o,
  output logic [31:0]          wp_data_o,
  output logic                 wp_we_o,
  output logic [31:0]          fwd_o,
  output hs32_stall            l1_o,
  output hs32_stall            l2_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e        state_r;
  state_e        state_nxt_s;
  logic [31:0]   addr_r;
  logic [31:0]   std_r;
  logic [31:0]   load_r;
  logic          we_r;
  logic [3:0]    rd_r;
  logic [CW-1:0] cnt_r;
  logic          err_r;
  logic          accept_s;
  logic          timeout_s;

  // Fields of the input packets this stage has no use for.
  logic unused_s;
  assign unused_s = ^{data_i.regwe, s3_i.rd, s3_i.vld};

  // Next-state decode and timeout detection.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = valid_i & s3_i.lsu;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        // Count equal to TIMEOUT means TIMEOUT wait cycles already elapsed.
        if ((TIMEOUT != 0) && (cnt_r == CW'(TIMEOUT)) && !bus.mem_ack_i) begin
          timeout_s = 1'b1;
        end else begin
          timeout_s = 1'b0;
        end
        if (bus.mem_ack_i) begin
          if (we_r) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = WB;
          end
        end else if (timeout_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WB: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request latches, load register, wait counter and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r <= 32'd0;
      std_r  <= 32'd0;
      load_r <= 32'd0;
      we_r   <= 1'b0;
      rd_r   <= 4'd0;
      cnt_r  <= '0;
      err_r  <= 1'b0;
    end else begin
      err_r <= timeout_s;
      if ((state_r == IDLE) && accept_s) begin
        addr_r <= data_i.res;
        std_r  <= data_i.std;
        we_r   <= data_i.memwe;
        rd_r   <= data_i.rd;
        cnt_r  <= '0;
      end
      if (state_r == REQ) begin
        if (bus.mem_ack_i && !we_r) begin
          load_r <= bus.mem_dat_i;
        end
        // Saturate so a disabled timeout never wraps the count.
        if (!bus.mem_ack_i && (cnt_r != {CW{1'b1}})) begin
          cnt_r <= cnt_r + CW'(1);
        end
      end
    end
  end

  assign bus.mem_addr_o = addr_r;
  assign bus.mem_dat_o  = std_r;
  assign bus.mem_we_o   = we_r;
  assign wp_addr_o      = rd_r;
  assign wp_data_o      = load_r;
  assign fwd_o          = load_r;
  assign err_o          = err_r;

  // State-decoded strobe, writeback enable and occupancy packets.
  always_comb begin
    bus.mem_stb_o = 1'b0;
    wp_we_o       = 1'b0;
    l1_o          = '0;
    l2_o          = '0;
    if (state_r == REQ) begin
      bus.mem_stb_o = 1'b1;
      l1_o.rd       = rd_r;
      l1_o.vld      = 1'b1;
      l1_o.lsu      = 1'b1;
    end else begin
      bus.mem_stb_o = 1'b0;
    end
    if (state_r == WB) begin
      wp_we_o  = 1'b1;
      l2_o.rd  = rd_r;
      l2_o.vld = 1'b1;
      l2_o.lsu = 1'b1;
    end else begin
      wp_we_o = 1'b0;
    end
  end

endmodule
